// File: rtl/instr_encoder_if.sv
// instr_encoder_if: input field bundle and output word/status channel of the
// RV32I instruction encoder. The encoder sits on the slave modport. The
// producer/consumer side sits on the master modport.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  // Input channel
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;

  // Output channel
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_word;
  logic             out_err;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  out_ready,
    output in_ready,
    output out_valid, out_word, out_err, out_count, err_count
  );

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output out_ready,
    input  in_ready,
    input  out_valid, out_word, out_err, out_count, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: 2-stage pipelined RV32I instruction encoder.
// S1 captures the input fields and computes the error flag. S2 holds the packed
// word presented to the consumer. Both stages have full valid/ready backpressure.
// Optional build macro IMM_RANGE_CHECK_EN: when defined, S1 also flags
// immediates that are not representable in the selected format. The word is
// still packed from the truncated bits either way.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input logic            CLK,
  input logic            RST,
  instr_encoder_if.slave bus
);

  localparam logic [2:0]  FMT_R    = 3'd0;
  localparam logic [2:0]  FMT_I    = 3'd1;
  localparam logic [2:0]  FMT_S    = 3'd2;
  localparam logic [2:0]  FMT_B    = 3'd3;
  localparam logic [2:0]  FMT_U    = 3'd4;
  localparam logic [2:0]  FMT_J    = 3'd5;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        err;
  } s1_t;

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_word_q, s2_word_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Handshake and advance signals
  logic        in_ready;
  logic        in_fire;
  logic        out_fire;
  logic        s2_load;
  logic        err1;
  logic [31:0] pack_word;

  assign out_fire = s2_valid_q && bus.out_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = bus.in_valid && in_ready;

  // Error flag for the incoming fields: illegal format always, range errors optionally
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    err1 = (bus.fmt > FMT_J);
`ifdef IMM_RANGE_CHECK_EN
    case (bus.fmt)
      FMT_I, FMT_S:
        if ($signed(bus.imm) < -32'sd2048 || $signed(bus.imm) > 32'sd2047)
          err1 = 1'b1;
      FMT_B:
        if ($signed(bus.imm) < -32'sd4096 || $signed(bus.imm) > 32'sd4094 || bus.imm[0])
          err1 = 1'b1;
      FMT_J:
        if ($signed(bus.imm) < -32'sd1048576 || $signed(bus.imm) > 32'sd1048574 ||
            bus.imm[0])
          err1 = 1'b1;
      FMT_U:
        if (bus.imm[11:0] != 12'd0)
          err1 = 1'b1;
      default: ;
    endcase
`endif
  end

  // Pack the S1 fields into an instruction word; illegal formats become a NOP
  always_comb begin
    pack_word = NOP_WORD;
    case (s1_q.fmt)
      FMT_R: pack_word = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd,
                          s1_q.opcode};
      FMT_I: pack_word = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_S: pack_word = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                          s1_q.imm[4:0], s1_q.opcode};
      FMT_B: pack_word = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                          s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      FMT_U: pack_word = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      FMT_J: pack_word = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                          s1_q.imm[19:12], s1_q.rd, s1_q.opcode};
      default: pack_word = NOP_WORD;
    endcase
  end

  // Next-state for both pipeline stages and the handshake counters
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_word_d  = s2_word_q;
    s2_err_d   = s2_err_q;
    out_cnt_d  = out_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d = '{fmt: bus.fmt, opcode: bus.opcode, rd: bus.rd, rs1: bus.rs1,
               rs2: bus.rs2, funct3: bus.funct3, funct7: bus.funct7,
               imm: bus.imm, err: err1};
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_word_d  = pack_word;
      s2_err_d   = s1_q.err;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end

    if (out_fire) begin
      out_cnt_d = out_cnt_q + 1'b1;
      if (s2_err_q)
        err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Control state, S2 output registers and counters, cleared by reset
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (RST) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_word_q  <= 32'd0;
      s2_err_q   <= 1'b0;
      out_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_word_q  <= s2_word_d;
      s2_err_q   <= s2_err_d;
      out_cnt_q  <= out_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // S1 field register
  always_ff @(posedge CLK) begin
    // NOTE: the S1 payload is left out of reset on purpose. It is only observed
    // while s1_valid_q is set, and that flag is reset.
    s1_q <= s1_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_word  = s2_word_q;
  assign bus.out_err   = s2_err_q;
  assign bus.out_count = out_cnt_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for instr_encoder with a scoreboard queue.
// The driver pushes each expected word when its input handshake is seen. The
// monitor pops one entry and compares it on every output handshake.
module tb_instr_encoder;

  localparam int CNT_W = 16;
`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  instr_encoder_if #(.CNT_W(CNT_W)) bus ();
  instr_encoder #(.CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   pop_cyc[$];
  int   n_checks    = 0;
  int   n_pass      = 0;
  int   exp_out_cnt = 0;
  int   exp_err_cnt = 0;
  int   cyc         = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compare every output handshake against the scoreboard head
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_word", bus.out_word, e.word);
          check("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
          pop_cyc.push_back(cyc);
          exp_out_cnt++;
          if (e.err) exp_err_cnt++;
        end
      end
    end
  end

  // Drive one input word; called just after a rising edge, returns just after
  // the rising edge that completed the handshake.
  task automatic send(input logic [2:0] fmt, input logic [6:0] opcode,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] funct3,
                      input logic [6:0] funct7, input logic [31:0] imm,
                      input logic [31:0] exp_word, input logic exp_err);
    exp_t e;
    int   waited;
    bus.fmt      = fmt;
    bus.opcode   = opcode;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.funct3   = funct3;
    bus.funct7   = funct7;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge CLK);
      if (bus.in_ready) begin
        e.word = exp_word;
        e.err  = exp_err;
        sb_q.push_back(e);
        break;
      end
      waited++;
      if (waited > 200) begin
        check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        break;
      end
    end
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait, bounded, until every expected word has been seen, then let counters settle
  task automatic drain();
    int waited;
    waited = 0;
    while (sb_q.size() != 0 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check("drain_remaining", sb_q.size(), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.fmt       = '0;
    bus.opcode    = '0;
    bus.rd        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.imm       = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_word", bus.out_word, 32'd0);
    check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    check("rst_out_count", {16'd0, bus.out_count}, 32'd0);
    check("rst_err_count", {16'd0, bus.err_count}, 32'd0);
    RST = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge CLK);
    #1;

    // Single I word: addi x1, x0, 5, with latency check
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    check("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
    @(posedge CLK);
    #1;
    check("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lat_word", bus.out_word, 32'h0050_0093);
    drain();
    check("t1_out_count", {16'd0, bus.out_count}, 32'd1);
    check("t1_err_count", {16'd0, bus.err_count}, 32'd0);

    // S/B/U/J back to back
    pop_cyc.delete();
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
    drain();
    check("b2b_pops", pop_cyc.size(), 32'd4);
    for (int i = 0; i + 1 < pop_cyc.size(); i++)
      check("b2b_consecutive", pop_cyc[i+1] - pop_cyc[i], 32'd1);
    check("b2b_out_count", {16'd0, bus.out_count}, exp_out_cnt);

    // Backpressure: third word must wait until the consumer resumes
    bus.out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd7, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    fork
      send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0113, 1'b0);
      begin
        repeat (3) begin
          @(negedge CLK);
          check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
          check("bp_word_stable", bus.out_word, 32'h0020_81B3);
        end
        @(posedge CLK);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_out_count", {16'd0, bus.out_count}, exp_out_cnt);
    check("bp_total", exp_out_cnt, 32'd8);

    // Range boundaries and illegal formats
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, RC);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h8000_0093, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h8000_0063, RC);
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0000_006F, RC);
    send(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0000_0037, RC);
    send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
    send(3'd6, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1);
    drain();
    check("rng_out_count", {16'd0, bus.out_count}, exp_out_cnt);
    check("rng_err_count", {16'd0, bus.err_count}, exp_err_cnt);
    check("rng_err_total", exp_err_cnt, RC ? 32'd6 : 32'd2);

    // Reset with two words in flight
    bus.out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0213, 1'b0);
    send(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0293, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_out_count", {16'd0, bus.out_count}, 32'd0);
    check("mid_rst_err_count", {16'd0, bus.err_count}, 32'd0);
    sb_q.delete();
    exp_out_cnt = 0;
    exp_err_cnt = 0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(negedge CLK);
    check("post_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
    @(posedge CLK);
    #1;
    send(3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0313, 1'b0);
    drain();
    check("post_rst_out_count", {16'd0, bus.out_count}, 32'd1);
    check("post_rst_err_count", {16'd0, bus.err_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Pipelined RISC-V RV32I instruction encoder. Inverse of the immediate-generation path: takes a format tag, register/funct fields and a 32-bit immediate, and produces the packed 32-bit instruction word.
- Used by the boot/self-test sequencer to write code into instruction memory, and by verification to generate stimulus.
- Valid/ready on input and output; 2-stage pipeline with full backpressure.

Parameters:
- CNT_W, 16, width of the emitted-word counter and the error counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- opcode  in  7  opcode[6:0].
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R only).
- imm  in  32  signed byte-offset or value immediate. U format: full value, upper 20 bits used.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts.
- out_word  out  32  encoded instruction.
- out_err  out  1  word flagged illegal/out of range. Qualified by out_valid.
- out_count  out  CNT_W  number of output handshakes.
- err_count  out  CNT_W  number of output handshakes with out_err=1.

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, out_word=0, out_err=0, out_count=0, err_count=0. in_ready=1 once RST deasserts.
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Stage 1 (S1): on input handshake, registers all fields and computes err1.
- Stage 2 (S2): packs the word from S1 registers. S2 drives out_word, out_err and out_valid.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_load.
- Latency: the word appears on out_valid 2 cycles after its input handshake when there is no stall. Throughput is 1 word/cycle.
- Order is preserved; no word is dropped or duplicated under any out_ready pattern.
- Packing (bits listed MSB to LSB):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - R ignores imm. U/J ignore rs1/rs2/funct3. I ignores rs2.
- Illegal fmt (6/7): out_word=32'h00000013 (NOP) and out_err=1, regardless of macro.
- Counters: out_count increments on every output handshake; err_count increments on output handshakes with out_err=1. Both wrap modulo 2^CNT_W, with no saturation.
- Simultaneous input and output handshakes on a full pipeline: both occur in the same cycle and contents shift by one.
- RST asserted mid-stream: in-flight words are discarded and never appear on the output. Counters clear.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: S1 sets err1 when the immediate is not representable.
  - I/S: outside [-2048, 2047].
  - B: outside [-4096, 4094], or imm[0]=1.
  - J: outside [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] != 0.
  - R: never.
  - The word is still emitted, using truncated bits per the packing rules.
- Undefined: no range check; out_err is set only for illegal fmt. Truncation behaviour is identical.

Test Plan:
- I: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_word=0x00500093 two cycles after handshake; out_err=0; out_count=1.
- S/B/U/J in back-to-back cycles, out_ready=1:
  - sw x2,8(x1) -> 0x0020A423.
  - beq x0,x0,-4 -> 0xFE000EE3.
  - lui x5,0x12345000 -> 0x123452B7.
  - jal x1,8 -> 0x008000EF.
  - Outputs on 4 consecutive cycles, in order.
- Backpressure: out_ready=0, in_valid held for 3 words -> in_ready low after 2 accepts; out_word stable. Raise out_ready -> 3 words in order, no duplicates; out_count=3.
- Range (macro defined): I, imm=2048, rd=1, opcode=0x13 -> out_word=0x80000093, out_err=1, err_count=1. Same input with macro undefined -> out_err=0, err_count=0.
- Illegal fmt=7 -> out_word=0x00000013, out_err=1 with either macro setting.
- Reset mid-stream: 2 words in flight, assert RST for one cycle -> out_valid=0 immediately, counters=0, no stale word after release.
